// File: rtl/lvds_tx_link_arbiter.sv
// Transmit-side LVDS link controller: sync training, idle fill, and round-robin
// framed arbitration of two requesters onto a single serializer input.
module lvds_tx_link_arbiter #(
  parameter int                 DATA_W       = 8,
  parameter int                 FRAME_LEN    = 4,
  parameter int                 TRAIN_CYCLES = 16,
  parameter logic [DATA_W-1:0]  SYNC_WORD    = 8'hA5,
  parameter logic [DATA_W-1:0]  IDLE_WORD    = 8'hBC,
  parameter logic [DATA_W-1:0]  HDR_WORD     = 8'hF0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              train_req,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_is_ctrl,
  input  logic              tx_ready,
  output logic [1:0]        grant,
  output logic              link_trained
);

  localparam int          FCW        = $clog2(FRAME_LEN + 1);
  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_CYCLES - 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_TRAIN, S_IDLE, S_HDR, S_DATA} state_t;

  state_t           state_q, state_d;
  logic [15:0]      train_cnt_q, train_cnt_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic             trained_q, trained_d;

  logic              owner_valid;
  logic [DATA_W-1:0] owner_data;
  logic              pref_valid;

  assign owner_valid  = owner_q ? req1_valid : req0_valid;
  assign owner_data   = owner_q ? req1_data  : req0_data;
  assign pref_valid   = rr_q    ? req1_valid : req0_valid;
  assign link_trained = trained_q;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    frame_cnt_d = frame_cnt_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    trained_d   = trained_q;
    tx_valid    = 1'b1;
    tx_data     = SYNC_WORD;
    tx_is_ctrl  = 1'b1;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    grant       = 2'b00;

    unique case (state_q)
      S_TRAIN: begin
        if (tx_ready) begin
          if (train_cnt_q == TRAIN_LAST) begin
            state_d     = S_IDLE;
            trained_d   = 1'b1;
            train_cnt_d = '0;
          end else begin
            train_cnt_d = train_cnt_q + 16'd1;
          end
        end
      end
      S_IDLE: begin
        tx_data = IDLE_WORD;
        if (tx_ready && (req0_valid || req1_valid)) begin
          owner_d = pref_valid ? rr_q : ~rr_q;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        tx_data = {HDR_WORD[DATA_W-1:1], owner_q};
        grant   = {owner_q, ~owner_q};
        if (tx_ready) begin
          state_d     = S_DATA;
          frame_cnt_d = '0;
        end
      end
      S_DATA: begin
        // Zero-latency pass-through; a requester stall is just a bubble.
        tx_valid   = owner_valid;
        tx_data    = owner_data;
        tx_is_ctrl = 1'b0;
        grant      = {owner_q, ~owner_q};
        req0_ready = ~owner_q & tx_ready;
        req1_ready =  owner_q & tx_ready;
        if (owner_valid && tx_ready) begin
          if (frame_cnt_q == FRAME_LAST) begin
            state_d = S_IDLE;
            rr_d    = ~owner_q;
          end else begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
          end
        end
      end
      default: ;
    endcase

    // Retraining overrides any completion decided above.
    if (train_req) begin
      state_d     = S_TRAIN;
      train_cnt_d = '0;
      frame_cnt_d = '0;
      trained_d   = 1'b0;
      if (state_q == S_HDR || state_q == S_DATA) rr_d = ~owner_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_TRAIN;
      train_cnt_q <= '0;
      frame_cnt_q <= '0;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      trained_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      trained_q   <= trained_d;
    end
  end

endmodule

// File: tb/tb_lvds_tx_link_arbiter.sv
// Randomized bench for lvds_tx_link_arbiter against a per-cycle behavioural
// model built from sync/frame word budgets rather than an FSM.
module tb_lvds_tx_link_arbiter;

  localparam int         W    = 8;
  localparam int         FL   = 4;
  localparam int         TC   = 16;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] IDLE = 8'hBC;
  localparam logic [7:0] HDR  = 8'hF0;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         train_req = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready;
  logic         tx_valid, tx_is_ctrl, link_trained;
  logic [W-1:0] tx_data;
  logic         tx_ready = 1'b0;
  logic [1:0]   grant;

  always #5 CLK = ~CLK;

  lvds_tx_link_arbiter #(
    .DATA_W(W), .FRAME_LEN(FL), .TRAIN_CYCLES(TC),
    .SYNC_WORD(SYNC), .IDLE_WORD(IDLE), .HDR_WORD(HDR)
  ) dut (
    .CLK(CLK), .RST(RST), .train_req(train_req),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_is_ctrl(tx_is_ctrl),
    .tx_ready(tx_ready), .grant(grant), .link_trained(link_trained)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: remaining sync words, frame in progress, header owed, data words left.
  int   syncs_left;
  bit   in_frame, hdr_pending;
  int   words_left;
  bit   pref, who;

  // Requester-side stimulus state and knobs.
  bit         v[2];
  logic [7:0] d[2];
  int         p[2];
  int         rdy_mode;
  int         tr_permille;
  bit         rdy_tog;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    syncs_left  = TC;
    in_frame    = 1'b0;
    hdr_pending = 1'b0;
    words_left  = 0;
    pref        = 1'b0;
    who         = 1'b0;
    v[0] = 1'b0; v[1] = 1'b0;
  endtask

  task automatic drive(input bit f0, input bit f1);
    for (int i = 0; i < 2; i++) begin
      if ((i == 0) ? f0 : f1) v[i] = 1'b0;
      if (!v[i] && ($urandom_range(99) < p[i])) begin
        v[i] = 1'b1;
        d[i] = 8'($urandom);
      end
    end
    req0_valid = v[0]; req0_data = d[0];
    req1_valid = v[1]; req1_data = d[1];
    rdy_tog = ~rdy_tog;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = rdy_tog;
      default: tx_ready = ($urandom_range(99) < 70);
    endcase
    train_req = ($urandom_range(999) < tr_permille);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, tx_valid, 1'b1);
    check({tag, "_data"},  tx_data,  SYNC);
    check({tag, "_ctrl"},  tx_is_ctrl, 1'b1);
    check({tag, "_rdy0"},  req0_ready, 1'b0);
    check({tag, "_rdy1"},  req1_ready, 1'b0);
    check({tag, "_grant"}, grant, 2'b00);
    check({tag, "_trained"}, link_trained, 1'b0);
  endtask

  task automatic cycle();
    logic       ev, ec, er0, er1;
    logic [7:0] ed;
    logic [1:0] eg;
    bit         acc, f0, f1;
    @(negedge CLK);
    ev = 1'b1; ed = SYNC; ec = 1'b1; er0 = 1'b0; er1 = 1'b0; eg = 2'b00;
    if (syncs_left > 0) begin
      ed = SYNC;
    end else if (!in_frame) begin
      ed = IDLE;
    end else if (hdr_pending) begin
      ed = HDR | 8'(who);
      eg = who ? 2'b10 : 2'b01;
    end else begin
      ev = v[who];
      ed = d[who];
      ec = 1'b0;
      eg = who ? 2'b10 : 2'b01;
      if (who) er1 = tx_ready; else er0 = tx_ready;
    end
    check("tx_valid", tx_valid, ev);
    check("tx_data", tx_data, ed);
    check("tx_is_ctrl", tx_is_ctrl, ec);
    check("req0_ready", req0_ready, er0);
    check("req1_ready", req1_ready, er1);
    check("grant", grant, eg);
    check("link_trained", link_trained, syncs_left == 0);

    acc = ev && tx_ready;
    f0  = er0 && v[0];
    f1  = er1 && v[1];
    if (train_req) begin
      if (in_frame) pref = ~who;
      syncs_left  = TC;
      in_frame    = 1'b0;
      hdr_pending = 1'b0;
    end else if (syncs_left > 0) begin
      if (acc) syncs_left--;
    end else if (!in_frame) begin
      if (acc && (v[0] || v[1])) begin
        who         = v[pref] ? pref : ~pref;
        in_frame    = 1'b1;
        hdr_pending = 1'b1;
      end
    end else if (hdr_pending) begin
      if (acc) begin
        hdr_pending = 1'b0;
        words_left  = FL;
      end
    end else if (acc) begin
      words_left--;
      if (words_left == 0) begin
        in_frame = 1'b0;
        pref     = ~who;
      end
    end

    @(posedge CLK);
    #1;
    drive(f0, f1);
  endtask

  initial begin
    bit found;
    model_reset();
    p[0] = 0; p[1] = 0; rdy_mode = 0; tr_permille = 0; rdy_tog = 1'b0;
    d[0] = '0; d[1] = '0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset("rst_init");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(1'b0, 1'b0);

    // Training with constant ready, then idle fill.
    repeat (TC + 4) cycle();

    // Single requester frame.
    p[0] = 100;
    repeat (8) cycle();
    p[0] = 0;
    repeat (6) cycle();

    // Both requesters busy: alternating frames.
    p[0] = 100; p[1] = 100;
    repeat (40) cycle();

    // Serializer stalls every other cycle during req1 traffic.
    p[0] = 0; p[1] = 100; rdy_mode = 1;
    repeat (30) cycle();

    // Retrain after the second data word of a req0 frame.
    p[0] = 100; p[1] = 100; rdy_mode = 0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      cycle();
      if (in_frame && !hdr_pending && !who && words_left == FL - 2) found = 1'b1;
    end
    check("wait_req0_mid_frame", found, 1'b1);
    train_req = 1'b1;
    cycle();
    repeat (TC + 12) cycle();

    // Asynchronous reset in the middle of a data phase.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      cycle();
      if (in_frame && !hdr_pending) found = 1'b1;
    end
    check("wait_data_phase", found, 1'b1);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_reset("rst_mid");
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    p[0] = 0; p[1] = 0;
    drive(1'b0, 1'b0);
    repeat (TC + 4) cycle();

    // Randomized traffic, stalls and occasional retraining.
    rdy_mode = 2;
    tr_permille = 8;
    for (int blk = 0; blk < 20; blk++) begin
      p[0] = $urandom_range(100);
      p[1] = $urandom_range(100);
      repeat (60) cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lvds_tx_link_arbiter.md
Name: lvds_tx_link_arbiter

Overview:
Transmit-side link controller for the inter-FPGA LVDS channel. It trains the link with a sync pattern and fills gaps with idle control words. It shares the single serializer input between two requesters: the local source and the echo-return path. Grants are round-robin in fixed-length frames, and each frame is prefixed with a header word that identifies the granted requester. It sits between the requester FIFOs and the LVDS serializer.

Parameters:
DATA_W, 8, word width of requester and serializer data.
FRAME_LEN, 4, data words per granted frame (>=1).
TRAIN_CYCLES, 16, number of accepted SYNC words per training sequence (1..65535).
SYNC_WORD, 8'hA5, training control word.
IDLE_WORD, 8'hBC, idle control word.
HDR_WORD, 8'hF0, header base; the LSB is replaced by the requester id.

Ports:
CLK  in  1  system clock; all state on rising edge
RST  in  1  asynchronous, active-high reset
train_req  in  1  single-cycle pulse; forces retraining
req0_valid  in  1  requester 0 word available
req0_data  in  DATA_W  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle
req1_valid  in  1  requester 1 word available
req1_data  in  DATA_W  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle
tx_valid  out  1  word presented to serializer
tx_data  out  DATA_W  word to serializer
tx_is_ctrl  out  1  1 = control word (SYNC/IDLE/HDR)
tx_ready  in  1  serializer accepts word (handshake = tx_valid & tx_ready)
grant  out  2  one-hot current owner; 00 outside HDR/DATA
link_trained  out  1  training sequence completed

Behaviour:
- Registered state: state {TRAIN, IDLE, HDR, DATA}, 16-bit train counter, frame word counter of width clog2(FRAME_LEN+1), 1-bit rr pointer, 1-bit owner id, link_trained flag. Outputs are combinational from state and inputs.
- Reset (async, while RST high): state=TRAIN, counters=0, rr=0 (req0 preferred), link_trained=0. Resulting outputs: tx_valid=1, tx_data=SYNC_WORD, tx_is_ctrl=1, req*_ready=0, grant=00.
- TRAIN: tx_valid=1, tx_data=SYNC_WORD, ctrl=1. Count accepted transfers. On the TRAIN_CYCLES-th accept: go to IDLE, set link_trained=1, clear the counter.
- IDLE: tx_valid=1, tx_data=IDLE_WORD, ctrl=1. On an accepted transfer with any req valid: owner = rr-preferred requester if it is valid, else the other; go to HDR. Stalled tx_ready means no state change.
- HDR: tx_data = HDR_WORD with LSB = owner id, ctrl=1, grant = one-hot(owner). On accept: go to DATA, frame counter=0.
- DATA: tx_valid = owner valid, tx_data = owner data, ctrl=0, owner ready = tx_ready, other ready=0. Count accepted words. On the FRAME_LEN-th accept: go to IDLE, rr = ~owner.
- A requester stall in DATA gives tx_valid=0 (a bubble). This is not a frame end and there is no timeout.
- Zero-latency pass-through: a requester word appears on tx_data in the same cycle as its valid. tx_data must stay stable while tx_valid=1 and tx_ready=0; requesters hold their data per the valid/ready rules.
- train_req, any state: the next state is TRAIN, counters clear, link_trained=0.
  - If in HDR/DATA, the frame aborts and rr = ~owner. Words already accepted stay sent.
  - train_req wins over a simultaneous frame completion or training completion.
- Requester valid during TRAIN: ignored, ready=0.
- FRAME_LEN=1: the frame is one data word; the counter compare must still work.

Test Plan:
1. Reset release, tx_ready=1 constant -> 16 words 0xA5 ctrl=1; IDLE 0xBC from the 17th cycle; link_trained=1 from the cycle after the 16th accept.
2. After training, req0 presents 0x11,0x22,0x33,0x44 -> serializer sees 0xBC, 0xF0(ctrl), 0x11,0x22,0x33,0x44 (ctrl=0); req0_ready pulses 4 times; then 0xBC resumes; grant=01 during HDR/DATA.
3. Both requesters continuously valid -> headers alternate 0xF0, 0xF1, 0xF0, each followed by exactly 4 words of the matching requester, with one IDLE word between frames.
4. tx_ready toggling 1/0 during a req1 frame -> tx_data held while stalled; req1_ready=0 whenever tx_ready=0; exactly 4 words delivered, none duplicated.
5. train_req pulse after the 2nd data word of a req0 frame -> next cycle SYNC 0xA5, link_trained=0, 16 syncs; the first frame after training is granted to req1 (0xF1) when both are valid.
6. RST asserted mid-DATA between clock edges -> outputs return to reset values without a clock edge; after release, the training sequence restarts from count 0.
